// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding common to uart_rx and uart_tx, and frame constants.
package uart_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'h0,
        START = 4'h1,
        D0    = 4'h2,
        D1    = 4'h3,
        D2    = 4'h4,
        D3    = 4'h5,
        D4    = 4'h6,
        D5    = 4'h7,
        D6    = 4'h8,
        D7    = 4'h9,
        STOP  = 4'hA
    } uart_state_e;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    function automatic logic is_data_state(input uart_state_e s);
        return (s >= D0) && (s <= D7);
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts 0..max(period,1)-1, flags the last cycle and wraps to 0 on its own.
module bit_timer #(
    parameter int COUNTER_WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [COUNTER_WIDTH-1:0] period,
    output logic                     terminal
);

    localparam logic [COUNTER_WIDTH-1:0] ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    logic [COUNTER_WIDTH-1:0] count_q;
    logic [COUNTER_WIDTH-1:0] count_d;
    logic [COUNTER_WIDTH-1:0] last_count;

    // A zero period behaves as a one-cycle bit.
    assign last_count = (period == '0) ? '0 : (period - ONE);
    assign terminal   = (count_q == last_count);

    always_comb begin
        count_d = count_q + ONE;
        if (clear || terminal) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, bit period taken from cycles_per_bit at byte acceptance.
//
// state  | meaning
// IDLE   | line high, ready for a byte
// START  | start bit (line low) for one bit period
// D0..D7 | data bit n from bit 0 of the shift register
// STOP   | stop bit (line high); ready again on its last cycle
module uart_tx
    import uart_pkg::*;
#(
    parameter int COUNTER_WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COUNTER_WIDTH-1:0] cycles_per_bit,
    input  logic [7:0]               data,
    input  logic                     data_valid,
    output logic                     data_ready,
    output logic                     uart_tx_out,
    output logic                     busy
);

    uart_state_e              state_q, state_d;
    logic [DATA_BITS-1:0]     shift_q, shift_d;
    logic [COUNTER_WIDTH-1:0] period_q, period_d;
    logic                     tx_q, tx_d;
    logic                     terminal;
    logic                     timer_clear;
    logic                     accept;

    bit_timer #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .period  (period_q),
        .terminal(terminal)
    );

    assign timer_clear = (state_q == IDLE);
    assign data_ready  = (state_q == IDLE) || ((state_q == STOP) && terminal);
    assign accept      = data_valid && data_ready;
    assign busy        = (state_q != IDLE);
    assign uart_tx_out = tx_q;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        period_d = period_q;
        tx_d     = 1'b1;

        case (state_q)
            IDLE: state_d = IDLE;
            START: if (terminal) state_d = D0;
            D0, D1, D2, D3, D4, D5, D6: begin
                if (terminal) begin
                    state_d = uart_state_e'(state_q + 4'd1);
                    shift_d = shift_q >> 1;
                end
            end
            D7: if (terminal) state_d = STOP;
            STOP: if (terminal) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Acceptance overrides the STOP->IDLE step so frames can run back to back.
        if (accept) begin
            state_d  = START;
            shift_d  = data;
            period_d = cycles_per_bit;
        end

        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (is_data_state(state_d)) begin
            tx_d = shift_d[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            period_q <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            period_q <= period_d;
            tx_q     <= tx_d;
        end
    end

endmodule
